// File: rtl/redstone_pkg.sv
// redstone_pkg: shared widths, FSM states and event record for the redstone I/O bridge
package redstone_pkg;
  localparam int STAMP_W = 16;
  localparam int TICK_DIV_DEFAULT = 5000000;
  localparam int EVT_DATA_W = 10;
  typedef enum logic [2:0] {WAIT, APPLY, PULSE, SETTLE, SAMPLE} state_t;
  typedef struct packed {
    logic [EVT_DATA_W-1:0] data;
    logic [STAMP_W-1:0]    stamp;
  } evt_t;
  function automatic logic [STAMP_W-1:0] stamp_inc(input logic [STAMP_W-1:0] s);
    return s + 1'b1;
  endfunction
endpackage

// File: rtl/redstone_io_bridge_fifo.sv
// redstone_evt_fifo: small synchronous FIFO for change events
// Push while full is accepted only when a pop happens in the same cycle.
module redstone_evt_fifo
  import redstone_pkg::*;
#(
  parameter int WIDTH = $bits(evt_t),
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/redstone_io_bridge.sv
// redstone_io_bridge: tick generator, input-command applier and output-change monitor
// Optional REDSTONE_BRIDGE_STATS_EN adds o_drop_cnt and o_cmd_cnt.
module redstone_io_bridge
  import redstone_pkg::*;
#(
  parameter int N_IN       = 10,
  parameter int N_OUT      = 10,
  parameter int TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [N_IN-1:0]    i_cmd_mask,
  input  logic [N_IN-1:0]    i_cmd_data,
  output logic               o_tick,
  output logic [N_IN-1:0]    o_circ_in,
  input  logic [N_OUT-1:0]   i_circ_out,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [N_OUT-1:0]   o_evt_data,
  output logic [STAMP_W-1:0] o_evt_stamp,
  output logic               o_overflow
`ifdef REDSTONE_BRIDGE_STATS_EN
  ,
  output logic [7:0]         o_drop_cnt,
  output logic [15:0]        o_cmd_cnt
`endif
);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  typedef struct packed {
    logic [N_OUT-1:0]   data;
    logic [STAMP_W-1:0] stamp;
  } slot_t;
  state_t state, next;
  logic [DIV_W-1:0] div;
  logic [N_IN-1:0] circ_in, mask_q, data_q;
  logic [STAMP_W-1:0] tick_cnt;
  logic [N_OUT-1:0] last;
  logic pending, overflow, full, empty, pop, change, push, drop, accept, apply;
  slot_t wr_evt, rd_evt;
  assign accept = i_cmd_valid & !pending;
  assign apply = (state == APPLY) & pending;
  assign pop = !empty & i_evt_ready;
  assign change = (state == SAMPLE) & (i_circ_out != last);
  assign push = change & (!full | pop);
  assign drop = change & full & !pop;
  assign wr_evt = '{data: i_circ_out, stamp: tick_cnt};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= WAIT;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      WAIT:    next = (i_run ? div == DIV_LAST : i_step) ? APPLY : WAIT;
      APPLY:   next = PULSE;
      PULSE:   next = SETTLE;
      SETTLE:  next = SAMPLE;
      SAMPLE:  next = WAIT;
      default: next = WAIT;
    endcase
  end
  // SAMPLE already counts as the first divider cycle so the run period is TICK_DIV+3
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div      <= '0;
      circ_in  <= '0;
      pending  <= 1'b0;
      mask_q   <= '0;
      data_q   <= '0;
      tick_cnt <= '0;
      last     <= '0;
      overflow <= 1'b0;
    end else begin
      div <= ((state == WAIT && i_run && div != DIV_LAST) || (state == SAMPLE && i_run)) ? div + 1'b1 : '0;
      if (apply) circ_in <= (circ_in & ~mask_q) | (data_q & mask_q);
      if (accept) begin
        pending <= 1'b1;
        mask_q  <= i_cmd_mask;
        data_q  <= i_cmd_data;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (state == PULSE) tick_cnt <= stamp_inc(tick_cnt);
      if (change) last <= i_circ_out;
      if (drop) overflow <= 1'b1;
    end
  end
  redstone_evt_fifo #(.WIDTH($bits(slot_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_evt),
    .rdata   (rd_evt),
    .full    (full),
    .empty   (empty)
  );
  assign o_tick = state == PULSE;
  assign o_circ_in = circ_in;
  assign o_cmd_ready = !pending;
  assign o_evt_valid = !empty;
  assign o_evt_data = rd_evt.data;
  assign o_evt_stamp = rd_evt.stamp;
  assign o_overflow = overflow;
`ifdef REDSTONE_BRIDGE_STATS_EN
  logic [7:0] drop_cnt;
  logic [15:0] cmd_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt <= '0;
      cmd_cnt  <= '0;
    end else begin
      drop_cnt <= drop_cnt + 8'(drop && drop_cnt != 8'hFF);
      cmd_cnt  <= cmd_cnt + 16'(apply);
    end
  end
  assign o_drop_cnt = drop_cnt;
  assign o_cmd_cnt = cmd_cnt;
`endif
endmodule

// File: tb/tb_redstone_io_bridge.sv
// tb_redstone_io_bridge: vector table, corner sequences and a random run against a queue-based reference
module tb_redstone_io_bridge;
  localparam int NI = 10, NO = 10, TD = 4, DEPTH = 4;
  logic clk = 0, rst_n = 0, run = 0, step = 0, cmd_valid = 0, evt_ready = 0;
  logic [NI-1:0] cmd_mask = '0, cmd_data = '0;
  logic [NO-1:0] circ_out = '0;
  logic cmd_ready, tick, evt_valid, overflow;
  logic [NI-1:0] circ_in;
  logic [NO-1:0] evt_data;
  logic [15:0] evt_stamp;
`ifdef REDSTONE_BRIDGE_STATS_EN
  logic [7:0] drop_cnt;
  logic [15:0] cmd_cnt;
`endif
  always #5 clk = ~clk;

  redstone_io_bridge #(.N_IN(NI), .N_OUT(NO), .TICK_DIV(TD), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_mask(cmd_mask), .i_cmd_data(cmd_data),
    .o_tick(tick), .o_circ_in(circ_in), .i_circ_out(circ_out),
    .o_evt_valid(evt_valid), .i_evt_ready(evt_ready), .o_evt_data(evt_data), .o_evt_stamp(evt_stamp),
    .o_overflow(overflow)
`ifdef REDSTONE_BRIDGE_STATS_EN
    , .o_drop_cnt(drop_cnt), .o_cmd_cnt(cmd_cnt)
`endif
  );

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a tick is a 4-cycle schedule after its trigger (apply, pulse, settle, sample)
  typedef struct {logic [NO-1:0] d; logic [15:0] s;} ev_t;
  ev_t q[$];
  int m_pos, m_wait, m_drops, m_cmds;
  bit m_pend, m_ovf;
  logic [NI-1:0] m_circ, m_mask, m_data;
  logic [15:0] m_tick;
  logic [NO-1:0] m_last;
  bit stub = 0, run_seg = 0;
  int cyc_n = 0, last_tick = -1;

  function automatic void model_reset();
    m_pos = 0; m_wait = 0; m_drops = 0; m_cmds = 0; m_pend = 0; m_ovf = 0;
    m_circ = '0; m_mask = '0; m_data = '0; m_tick = '0; m_last = '0;
    q.delete();
  endfunction

  task automatic cyc();
    bit pop, full0, acc;
    logic [NI-1:0] pre_circ;
    pre_circ = m_circ;
    pop = q.size() > 0 && evt_ready;
    full0 = q.size() == DEPTH;
    acc = cmd_valid && !m_pend;
    if (pop) void'(q.pop_front());
    if (m_pos == 0) begin
      if (run) begin
        if (m_wait == TD - 1) begin m_wait = 0; m_pos = 1; end
        else m_wait++;
      end else begin
        m_wait = 0;
        if (step) m_pos = 1;
      end
    end else if (m_pos == 1) begin
      if (m_pend) begin
        m_circ = (m_circ & ~m_mask) | (m_data & m_mask);
        m_pend = 0;
        m_cmds++;
      end
      m_pos = 2;
    end else if (m_pos == 2) begin
      m_tick = m_tick + 16'd1;
      m_pos = 3;
    end else if (m_pos == 3) begin
      m_pos = 4;
    end else begin
      if (circ_out !== m_last) begin
        if (full0 && !pop) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else q.push_back('{circ_out, m_tick});
        m_last = circ_out;
      end
      m_wait = run ? 1 : 0;
      m_pos = 0;
    end
    if (acc) begin m_pend = 1; m_mask = cmd_mask; m_data = cmd_data; end
    @(posedge clk);
    #1;
    cyc_n++;
    if (stub) circ_out = pre_circ;
    chk("tick", tick, m_pos == 2);
    chk("circ_in", circ_in, m_circ);
    chk("cmd_ready", cmd_ready, !m_pend);
    chk("evt_valid", evt_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("evt_data", evt_data, q[0].d);
      chk("evt_stamp", evt_stamp, q[0].s);
    end
    chk("overflow", overflow, m_ovf);
`ifdef REDSTONE_BRIDGE_STATS_EN
    chk("drop_cnt", drop_cnt, m_drops);
    chk("cmd_cnt", cmd_cnt, m_cmds & 16'hFFFF);
`endif
    if (tick) begin
      if (run_seg && last_tick >= 0) chk("tick_period", cyc_n - last_tick, TD + 3);
      last_tick = cyc_n;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("rst_tick", tick, 0);
    chk("rst_circ_in", circ_in, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  typedef struct {
    logic step, valid;
    logic [NI-1:0] mask, data;
    logic tick;
    logic [NI-1:0] circ;
    logic rdy, evv;
  } vec_t;
  vec_t tbl[11];
  function automatic vec_t v(input bit s, input bit va, input int m, input int d,
                             input bit t, input int c, input bit r, input bit e);
    return '{s, va, NI'(m), NI'(d), t, NI'(c), r, e};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_ticks, n;
    do_reset();
    // idle: no run, no step
    idle_ticks = 0;
    repeat (100) begin
      cyc();
      if (tick) idle_ticks++;
    end
    chk("idle_ticks", idle_ticks, 0);
    chk("idle_evt_valid", evt_valid, 0);
    // command / step sequence, circuit output held at 0x005
    tbl[0]  = v(0, 1, 'h003, 'h001, 0, 'h000, 0, 0);
    tbl[1]  = v(1, 1, 'h0F0, 'h0A0, 0, 'h000, 0, 0);
    tbl[2]  = v(0, 1, 'h0F0, 'h0A0, 1, 'h001, 1, 0);
    tbl[3]  = v(0, 1, 'h0F0, 'h0A0, 0, 'h001, 0, 0);
    tbl[4]  = v(0, 0, 'h000, 'h000, 0, 'h001, 0, 0);
    tbl[5]  = v(0, 0, 'h000, 'h000, 0, 'h001, 0, 1);
    tbl[6]  = v(1, 0, 'h000, 'h000, 0, 'h001, 0, 1);
    tbl[7]  = v(0, 0, 'h000, 'h000, 1, 'h0A1, 1, 1);
    tbl[8]  = v(0, 0, 'h000, 'h000, 0, 'h0A1, 1, 1);
    tbl[9]  = v(0, 0, 'h000, 'h000, 0, 'h0A1, 1, 1);
    tbl[10] = v(0, 0, 'h000, 'h000, 0, 'h0A1, 1, 1);
    circ_out = 'h005;
    for (int i = 0; i < 11; i++) begin
      step = tbl[i].step; cmd_valid = tbl[i].valid; cmd_mask = tbl[i].mask; cmd_data = tbl[i].data;
      cyc();
      chk($sformatf("vec%0d_tick", i), tick, tbl[i].tick);
      chk($sformatf("vec%0d_circ_in", i), circ_in, tbl[i].circ);
      chk($sformatf("vec%0d_ready", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_evt_valid", i), evt_valid, tbl[i].evv);
    end
    chk("vec_stamp", evt_stamp, 1);
    chk("vec_data", evt_data, 'h005);
    step = 0; cmd_valid = 0; evt_ready = 1;
    cyc();
    evt_ready = 0;
    // overflow: five distinct outputs with no consumer
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      circ_out = NO'(k);
      step = 1;
      cyc();
      step = 0;
      repeat (4) cyc();
    end
    chk("ovf_sticky", overflow, 1);
`ifdef REDSTONE_BRIDGE_STATS_EN
    chk("ovf_drop_cnt", drop_cnt, 1);
`endif
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_data", evt_data, k);
      chk("ovf_stamp", evt_stamp, k);
      evt_ready = 1;
      cyc();
    end
    evt_ready = 0;
    chk("ovf_drained", evt_valid, 0);
    // free-running with circuit stub echoing circ_in one cycle late
    run = 1; stub = 1; run_seg = 1; last_tick = -1;
    repeat (300) begin
      cmd_valid = $urandom_range(0, 2) == 0;
      cmd_mask = NI'($urandom);
      cmd_data = NI'($urandom);
      evt_ready = $urandom_range(0, 1) == 1;
      cyc();
    end
    run = 0; stub = 0; run_seg = 0;
    // stepped with random outputs from a small value set
    repeat (300) begin
      step = $urandom_range(0, 3) == 0;
      circ_out = NO'($urandom_range(0, 3));
      cmd_valid = $urandom_range(0, 2) == 0;
      cmd_mask = NI'($urandom);
      cmd_data = NI'($urandom);
      evt_ready = $urandom_range(0, 2) != 0;
      cyc();
    end
    step = 0; cmd_valid = 0;
    // reset asserted while o_tick is high
    run = 1;
    n = 0;
    while (m_pos != 2 && n < 20) begin
      cyc();
      n++;
    end
    chk("pulse_reached", tick, 1);
    rst_n = 0;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_circ_in", circ_in, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_evt_valid", evt_valid, 0);
    chk("arst_overflow", overflow, 0);
    model_reset();
    run = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
